pwm_pulse_measure: RTL and testbench
====================================

# pwm_pulse_measure

Input-side measurement stage of the PWM analyzer. Synchronizes the raw PWM input, counts the high time of each pulse in clock cycles, and classifies it against the LOW/HIGH thresholds. It hands a one-cycle `valid` strobe, the measured width and a 2-bit level code to the downstream display/decision logic. It also flags pulses that are too long and inputs that have gone silent.

## Interface

- `MAX_COUNTER_VALUE`, 2000: longest legal high time in cycles; the counter saturates here.
- `HIGH_COUNTER_VALUE`, 1900: widths strictly above this value classify as HIGH.
- `LOW_COUNTER_VALUE`, 1100: widths strictly below this value classify as LOW.
- `STALE_CYCLES`, 50000: number of cycles without a valid measurement before `stale` asserts.
- `clk`  in  1  system clock (1 MHz nominal).
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `ena`  in  1  block enable; low forces IDLE.
- `pwm_in`  in  1  raw asynchronous PWM input.
- `width`  out  11  last measured high time in cycles.
- `level`  out  2  classification: 00 LOW, 01 MID, 10 HIGH, 11 TIMEOUT.
- `valid`  out  1  one-cycle strobe when `width`/`level` update.
- `stale`  out  1  no valid measurement within `STALE_CYCLES`.

## Operation

- **Input path:** 2-flop synchronizer `s1`→`s2`, plus `s_prev` for edge detection.
  - rise = `s2 & ~s_prev`
  - fall = `~s2 & s_prev`
- **FSM states:** IDLE, ARMED, MEASURE, WAIT_LOW.
  - IDLE: wait until `s2`=0, then go to ARMED. This prevents measuring a partial pulse after reset or enable.
  - ARMED: on rise, load `cnt`=1 and go to MEASURE.
  - MEASURE, `s2`=1 and `cnt`<MAX: increment `cnt`.
  - MEASURE, `s2`=1 and `cnt`==MAX: timeout. Registers load `width`=MAX, `level`=11, `valid`=1; go to WAIT_LOW.
  - MEASURE, fall: registers load `width`=`cnt`, `level`=classify(`cnt`), `valid`=1; go to ARMED.
  - WAIT_LOW: on `s2`=0, go to ARMED. No output is produced for the tail of a timed-out pulse.
- **Classify(w):**
  - w < LOW → 00
  - w > HIGH → 10
  - otherwise → 01 (w==LOW and w==HIGH are MID)
- **Width rules:** `cnt` is 11 bits wide and never exceeds MAX. The HIGH/LOW comparisons are unsigned.
- **Stale counter:** 16-bit `stale_cnt`.
  - Clears to 0 and drops `stale` on every `valid`, including a timeout.
  - Otherwise increments while `ena`=1.
  - When it reaches STALE_CYCLES: `stale`=1 and the counter holds.
- **`ena`=0:** FSM goes to IDLE and `cnt`=0. `width`, `level` and `stale` hold their values, `valid`=0, and `stale_cnt` holds.
  - Synchronizer flops keep running.
- **Reset values:** `width`=0, `level`=00, `valid`=0, `stale`=1, FSM=IDLE, `cnt`=0, `stale_cnt`=0, synchronizer flops=0.

## Timing

- **Latency:** `pwm_in` first sampled low at clock edge k gives `valid`=1 during the cycle after edge k+2, for exactly one cycle.
- **Width accuracy:** a pulse sampled high on N consecutive edges reports `width`=N.
- **Minimum pulse:** one sampled-high edge gives `width`=1. Pulses shorter than one period may be missed.
- **Timeout:** asserts on the (MAX+1)-th consecutive high sample.
  - A pulse of exactly MAX samples reports `width`=MAX with `level`=10.
- **Back-to-back pulses:** minimum spacing is one low sample.
  - A fall followed by a rise one cycle later is measured correctly, because ARMED detects the rise on the next edge.
- **Stale vs valid:** if `valid` and the STALE_CYCLES limit coincide in the same cycle, `valid` wins and `stale`=0.
- **Reset:** `rst` asserts asynchronously at any point, including mid-pulse. After release, the current high pulse is ignored (IDLE).
- **Enable:** the first valid after `ena` rises requires a full low→high→low sequence.

## Test plan

- Reset released, `ena`=1, `pwm_in` high 1500 cycles then low → single `valid`, `width`=1500, `level`=01, `stale`=0; `valid` lands 2 cycles after the first low sample.
- Pulses of 1000, 1100, 1900 and 1950 cycles → `level` 00, 01, 01, 10 respectively, with exact widths.
- `pwm_in` high 2500 cycles → one `valid` with `width`=2000, `level`=11 on the 2001st high sample; no second `valid` at the falling edge; the next 1500-cycle pulse measures normally.
- `pwm_in` held low for 50000 cycles after a valid measurement → `stale` rises at cycle 50000 and clears on the next `valid`.
- `rst` pulsed, or `ena` toggled 0→1, in the middle of a high pulse → no `valid` for that pulse; the next full 1200-cycle pulse gives `width`=1200, `level`=01.
- `ena`=0 with pulses present → `valid` stays 0 and `width`/`level` hold their previous values.

Source files
------------

// File: rtl/pwm_pulse_measure.sv
// PWM input measurement stage: synchronizes pwm_in, measures each high pulse in
// clock cycles, classifies it against LOW/HIGH thresholds and flags timeouts/staleness.
module pwm_pulse_measure #(
  parameter int MAX_COUNTER_VALUE  = 2000,
  parameter int HIGH_COUNTER_VALUE = 1900,
  parameter int LOW_COUNTER_VALUE  = 1100,
  parameter int STALE_CYCLES       = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        pwm_in,
  output logic [10:0] width,
  output logic [1:0]  level,
  output logic        valid,
  output logic        stale
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] MEASURE  = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;

  localparam logic [1:0] LVL_LOW     = 2'b00;
  localparam logic [1:0] LVL_MID     = 2'b01;
  localparam logic [1:0] LVL_HIGH    = 2'b10;
  localparam logic [1:0] LVL_TIMEOUT = 2'b11;

  localparam logic [10:0] CNT_MAX     = 11'(MAX_COUNTER_VALUE);
  localparam logic [10:0] CNT_HIGH    = 11'(HIGH_COUNTER_VALUE);
  localparam logic [10:0] CNT_LOW     = 11'(LOW_COUNTER_VALUE);
  localparam logic [15:0] STALE_LIMIT = 16'(STALE_CYCLES);

  logic        s1;
  logic        s2;
  logic        s_prev;
  logic [1:0]  sync_ok;
  logic        rise;
  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [10:0] cnt;
  logic [10:0] cnt_next;
  logic        done;
  logic [10:0] done_width;
  logic [1:0]  done_level;
  logic [15:0] stale_cnt;

  function automatic logic [1:0] classify(input logic [10:0] w);
    if (w < CNT_LOW)
      return LVL_LOW;
    else if (w > CNT_HIGH)
      return LVL_HIGH;
    else
      return LVL_MID;
  endfunction

  assign rise = s2 & ~s_prev;

  // NOTE: every output of this block is given a default first so no path leaves a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done       = 1'b0;
    done_width = cnt;
    done_level = LVL_MID;
    if (!ena) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        // sync_ok keeps IDLE from trusting the reset zeros in s2 while a pulse may be in flight
        IDLE: if (sync_ok[1] && !s2) state_next = ARMED;
        ARMED: begin
          if (rise) begin
            cnt_next   = 11'd1;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (s2) begin
            if (cnt < CNT_MAX) begin
              cnt_next = cnt + 11'd1;
            end else begin
              done       = 1'b1;
              done_width = CNT_MAX;
              done_level = LVL_TIMEOUT;
              state_next = WAIT_LOW;
            end
          end else begin
            done       = 1'b1;
            done_width = cnt;
            done_level = classify(cnt);
            state_next = ARMED;
          end
        end
        WAIT_LOW: if (!s2) state_next = ARMED;
        default:  state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s_prev    <= 1'b0;
      sync_ok   <= 2'b00;
      state     <= IDLE;
      cnt       <= '0;
      width     <= '0;
      level     <= LVL_LOW;
      valid     <= 1'b0;
      stale     <= 1'b1;
      stale_cnt <= '0;
    end else begin
      s1      <= pwm_in;
      s2      <= s1;
      s_prev  <= s2;
      sync_ok <= {sync_ok[0], 1'b1};
      state   <= state_next;
      cnt     <= cnt_next;
      valid   <= done;
      if (done) begin
        width     <= done_width;
        level     <= done_level;
        stale_cnt <= '0;
        stale     <= 1'b0;
      end else if (ena && stale_cnt != STALE_LIMIT) begin
        stale_cnt <= stale_cnt + 16'd1;
        if (stale_cnt == STALE_LIMIT - 16'd1) stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_pulse_measure.sv
// Directed bench for pwm_pulse_measure: pulse widths, classification boundaries,
// timeout, stale detection, reset/enable mid-pulse and enable hold behaviour.
module tb_pwm_pulse_measure;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        pwm_in;
  logic [10:0] width;
  logic [1:0]  level;
  logic        valid;
  logic        stale;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int q_w[$];
  int q_l[$];
  int q_c[$];

  pwm_pulse_measure dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .pwm_in (pwm_in),
    .width  (width),
    .level  (level),
    .valid  (valid),
    .stale  (stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      q_w.push_back(int'(width));
      q_l.push_back(int'(level));
      q_c.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic clear_q();
    q_w.delete();
    q_l.delete();
    q_c.delete();
  endtask

  // Called at a negedge; returns the first high-sample edge and first low-sample edge.
  task automatic drive_pulse(input int hi, input int lo, output int rise_edge, output int fall_edge);
    pwm_in    = 1'b1;
    rise_edge = cyc + 1;
    repeat (hi) @(negedge clk);
    pwm_in    = 1'b0;
    fall_edge = cyc + 1;
    repeat (lo) @(negedge clk);
  endtask

  task automatic expect_one(input string tag, input int w, input int l);
    check({tag, "_count"}, q_w.size(), 1);
    if (q_w.size() >= 1) begin
      check({tag, "_width"}, q_w[0], w);
      check({tag, "_level"}, q_l[0], l);
    end
  endtask

  int re, fe, v_cyc;
  int widths[6] = '{1000, 1100, 1900, 1950, 2000, 1};
  int levels[6] = '{0, 1, 1, 2, 2, 0};

  initial begin
    rst    = 1'b1;
    ena    = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_width", int'(width), 0);
    check("reset_level", int'(level), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_stale", int'(stale), 1);

    rst = 1'b0;
    ena = 1'b1;
    repeat (10) @(negedge clk);
    check("stale_before_first", int'(stale), 1);

    // Basic 1500-cycle pulse with latency check
    clear_q();
    drive_pulse(1500, 10, re, fe);
    expect_one("p1500", 1500, 1);
    if (q_c.size() >= 1) check("p1500_latency", q_c[0], fe + 2);
    check("p1500_stale", int'(stale), 0);

    // Classification boundaries, max legal width and minimum pulse
    for (int i = 0; i < 6; i++) begin
      clear_q();
      drive_pulse(widths[i], 6, re, fe);
      expect_one($sformatf("cls%0d", widths[i]), widths[i], levels[i]);
    end

    // Back-to-back pulses separated by a single low sample
    clear_q();
    drive_pulse(3, 1, re, fe);
    drive_pulse(4, 6, re, fe);
    check("b2b_count", q_w.size(), 2);
    if (q_w.size() >= 2) begin
      check("b2b_first_width", q_w[0], 3);
      check("b2b_second_width", q_w[1], 4);
    end

    // Timeout on the 2001st high sample, nothing on the tail
    clear_q();
    drive_pulse(2500, 10, re, fe);
    expect_one("timeout", 2000, 3);
    if (q_c.size() >= 1) check("timeout_cycle", q_c[0], re + 2002);
    clear_q();
    drive_pulse(1500, 10, re, fe);
    expect_one("after_timeout", 1500, 1);

    // Stale after 50000 cycles without a measurement
    v_cyc = (q_c.size() >= 1) ? q_c[0] : cyc;
    while (cyc < v_cyc + 49999) @(negedge clk);
    check("stale_at_49999", int'(stale), 0);
    @(negedge clk);
    check("stale_at_50000", int'(stale), 1);
    repeat (20) @(negedge clk);
    check("stale_holds", int'(stale), 1);
    clear_q();
    drive_pulse(1200, 10, re, fe);
    expect_one("stale_clear", 1200, 1);
    check("stale_cleared", int'(stale), 0);

    // Asynchronous reset in the middle of a pulse
    clear_q();
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("async_rst_width", int'(width), 0);
    check("async_rst_stale", int'(stale), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_partial_count", q_w.size(), 0);
    drive_pulse(1200, 10, re, fe);
    expect_one("rst_next", 1200, 1);

    // Enable toggled in the middle of a pulse
    clear_q();
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    repeat (300) @(negedge clk);
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    check("ena_partial_count", q_w.size(), 0);
    drive_pulse(1200, 10, re, fe);
    expect_one("ena_next", 1200, 1);

    // Enable low: outputs hold, no strobe
    clear_q();
    ena = 1'b0;
    drive_pulse(1000, 10, re, fe);
    drive_pulse(1950, 10, re, fe);
    check("dis_count", q_w.size(), 0);
    check("dis_width_hold", int'(width), 1200);
    check("dis_level_hold", int'(level), 1);
    check("dis_stale_hold", int'(stale), 0);
    ena = 1'b1;
    repeat (5) @(negedge clk);
    drive_pulse(1950, 10, re, fe);
    expect_one("reenable", 1950, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
